cr_ce_gen: RTL and testbench
============================

# cr_ce_gen

Parametrised fractional clock-enable generator for the CreatiVision core and later consoles on the same framework. It replaces hand-coded accumulators and divider counters with N independent channels. Each channel produces single-cycle `ce` pulses at an average rate of f_clk·INC/MOD, plus an optional two-phase `ph1`/`ph2` split for 6502-style Enable/clk_ena pairs. The block sits beside the system top, is driven from `clk`, and feeds T65, VDP, PIA and PSG enables. Ratios are reprogrammable at runtime, and a `sync` input realigns all channels.

## Interface
- `CHANNELS`, 2: number of independent enable channels (1..8)
- `INC_W`, 16: width of increment and modulus values
- `DEF_INC`, 2328: reset increment for every channel
- `DEF_MOD`, 25000: reset modulus for every channel
- `DEF_TWO_PHASE`, 1: reset value of the two-phase mode for every channel

- `clk`  in  1  system clock
- `reset_n`  in  1  synchronous, active-low reset
- `run`  in  1  global run; low freezes all accumulators
- `sync`  in  1  clears every channel accumulator and phase
- `cfg_we`  in  1  configuration write strobe
- `cfg_ch`  in  $clog2(CHANNELS) (min 1)  channel selected by `cfg_we`
- `cfg_inc`  in  INC_W  new increment
- `cfg_mod`  in  INC_W  new modulus
- `cfg_two_phase`  in  1  new two-phase mode
- `ce`  out  CHANNELS  one-cycle tick pulse per channel
- `ph1`  out  CHANNELS  tick on even phase (two-phase mode only)
- `ph2`  out  CHANNELS  tick on odd phase (two-phase mode only)

## Operation
- Per-channel state:
  - `acc` is INC_W+1 bits.
  - `phase` is 1 bit.
  - `inc`, `mod` and `two_phase` are configuration registers.
- Effective increment `einc = (inc > mod) ? mod : inc`. Clamping gives one tick per cycle.
- Each cycle with `run`=1, `sync`=0 and `mod`≠0, the channel computes `sum = acc + einc`:
  - If `sum >= mod`: `acc <= sum - mod`, tick=1.
  - Otherwise: `acc <= sum`, tick=0.
  - No overflow: `acc < mod` always holds, and `sum < 2^(INC_W+1)`.
- A channel with `mod`=0 or `inc`=0 never ticks, and its `acc` stays at 0.
- On a tick:
  - `ce` pulses.
  - In two-phase mode, `ph1` pulses if `phase`=0 and `ph2` pulses if `phase`=1, then `phase` toggles.
  - In single-phase mode, `ph1`/`ph2` stay 0 and `phase` stays 0.
- `cfg_we`:
  - Loads `inc`, `mod` and `two_phase` into channel `cfg_ch`.
  - Clears that channel's `acc` and `phase`.
  - That channel emits no tick in the write cycle.
  - Other channels are unaffected.
  - If `cfg_ch` ≥ CHANNELS, the write is ignored.
- `sync`=1 clears `acc` and `phase` on all channels and suppresses all ticks in that cycle.
  - If `cfg_we` is asserted in the same cycle, the configuration is still written.
- `run`=0 holds `acc` and `phase`, and no ticks occur. Configuration writes are still accepted.
- Reset (`reset_n`=0):
  - `acc`=0, `phase`=0.
  - `inc`=DEF_INC, `mod`=DEF_MOD, `two_phase`=DEF_TWO_PHASE.
  - `ce`=`ph1`=`ph2`=0.
  - Reset takes priority over `sync`, `cfg_we` and `run`.

## Timing
- All outputs are registered. A tick decided in cycle k appears on `ce`/`ph*` during cycle k+1, high for exactly one cycle.
- Cycle numbering: cycle 1 is the first clock edge with `reset_n`=1 and `run`=1. After cycle k, with no wraps yet, `acc` = k·einc.
- Long-run tick count over M cycles is floor(M·einc/mod) ± 1. The remainder carries across wraps with no drift.
- Clearing and first tick:
  - Clearing by `cfg_we` or `sync` in cycle k: `acc`=0 after cycle k.
  - Accumulation resumes in cycle k+1.
  - The first post-clear tick is always `ph1` in two-phase mode.
- Outputs from a tick decided in the cycle before reset or `sync` still appear in the following cycle. Only reset forces them to 0.

## Structure
- Package `cr_ce_pkg` holds:
  - typedef `ce_cfg_t` {inc, mod, two_phase}
  - constants `CE_DEF_INC`, `CE_DEF_MOD` and `CE_DEF_TWO_PHASE`
  - function `ce_clamp(inc, mod)`
- Sub-module `cr_ce_chan` holds one channel's accumulator, phase and registered outputs. `cr_ce_gen` instantiates it CHANNELS times in a generate loop and performs `cfg_ch` decode.

## Test plan
- **Default ratio:** reset with defaults, `run`=1.
  - First `ce` appears in cycle 12, because 11·2328 = 25608 ≥ 25000; the residual `acc` is 608.
  - That tick is `ph1`; the next tick is `ph2`.
  - Exactly 2328 ticks occur in 25000 cycles.
- **Integer divide:** write inc=1, mod=4, two_phase=0 to channel 1.
  - `ce[1]` pulses every 4th cycle; `ph1[1]`/`ph2[1]` stay 0.
  - Channel 0 cadence is unchanged.
- **Clamp and disable:**
  - inc=5, mod=3: `ce` high every cycle.
  - inc=0, mod=7: no `ce` over 1000 cycles.
  - mod=0: no `ce` and `acc` stays 0.
- **Sync mid-operation:** run two channels with different ratios, then assert `sync` for one cycle.
  - Both `acc` values read 0.
  - Next ticks occur at the first-tick cycle counts measured from the sync, each starting with `ph1`.
  - `cfg_we` in the same cycle still applies.
- **Freeze:** drop `run` for 100 cycles.
  - No ticks and no change in `acc`.
  - On resume, the tick sequence continues exactly where it paused.
- **Reset mid-operation:** assert `reset_n`=0 for one cycle after reprogramming.
  - All outputs are 0 the next cycle.
  - Configuration reverts to DEF values.
  - The default-ratio scenario timing repeats.

Source files
------------

// File: rtl/cr_ce_pkg.sv
// Shared types, reset defaults and helpers for the fractional clock-enable generator.
package cr_ce_pkg;

  // Container width for configuration values; channels use the low INC_W bits.
  localparam int CE_CFG_W = 32;

  localparam int CE_DEF_INC       = 2328;
  localparam int CE_DEF_MOD       = 25000;
  localparam bit CE_DEF_TWO_PHASE = 1'b1;

  typedef struct packed {
    logic [CE_CFG_W-1:0] inc;
    logic [CE_CFG_W-1:0] mod;
    logic                two_phase;
  } ce_cfg_t;

  // An increment above the modulus would need more than one tick per cycle,
  // so it saturates at the modulus (tick every cycle).
  function automatic logic [CE_CFG_W-1:0] ce_clamp(input logic [CE_CFG_W-1:0] inc,
                                                   input logic [CE_CFG_W-1:0] mod);
    return (inc > mod) ? mod : inc;
  endfunction

endpackage

// File: rtl/cr_ce_chan.sv
// One enable channel: fractional accumulator, phase toggle and registered outputs.
module cr_ce_chan
  import cr_ce_pkg::*;
#(
  parameter int INC_W         = 16,
  parameter int DEF_INC       = CE_DEF_INC,
  parameter int DEF_MOD       = CE_DEF_MOD,
  parameter bit DEF_TWO_PHASE = CE_DEF_TWO_PHASE
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    run,
  input  logic    sync,
  input  logic    cfg_we,
  input  ce_cfg_t cfg,
  output logic    ce,
  output logic    ph1,
  output logic    ph2
);

  ce_cfg_t              cfg_reg;
  logic [INC_W:0]       acc_reg, acc_next;
  logic                 phase_reg, phase_next;
  logic                 ce_reg, ph1_reg, ph2_reg;
  logic                 ce_next, ph1_next, ph2_next;
  logic [CE_CFG_W-1:0]  einc;
  logic [CE_CFG_W:0]    sum;
  logic                 wrap;
  logic                 mod_ok;

  // Accumulate, decide the tick and the next phase; clears beat accumulation.
  always_comb begin
    acc_next   = acc_reg;
    phase_next = phase_reg;
    ce_next    = 1'b0;
    ph1_next   = 1'b0;
    ph2_next   = 1'b0;
    einc       = ce_clamp(cfg_reg.inc, cfg_reg.mod);
    sum        = (CE_CFG_W+1)'(acc_reg) + (CE_CFG_W+1)'(einc);
    wrap       = (sum >= (CE_CFG_W+1)'(cfg_reg.mod));
    mod_ok     = (cfg_reg.mod != '0);
    if (cfg_we || sync) begin
      acc_next   = '0;
      phase_next = 1'b0;
    end else if (run && mod_ok) begin
      if (wrap) begin
        acc_next = (INC_W+1)'(sum - (CE_CFG_W+1)'(cfg_reg.mod));
        ce_next  = 1'b1;
        if (cfg_reg.two_phase) begin
          ph1_next   = ~phase_reg;
          ph2_next   = phase_reg;
          phase_next = ~phase_reg;
        end
      end else begin
        acc_next = (INC_W+1)'(sum);
      end
    end
  end

  // State, configuration and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cfg_reg.inc       <= CE_CFG_W'(DEF_INC);
      cfg_reg.mod       <= CE_CFG_W'(DEF_MOD);
      cfg_reg.two_phase <= DEF_TWO_PHASE;
      acc_reg           <= '0;
      phase_reg         <= 1'b0;
      ce_reg            <= 1'b0;
      ph1_reg           <= 1'b0;
      ph2_reg           <= 1'b0;
    end else begin
      if (cfg_we) begin
        cfg_reg <= cfg;
      end
      acc_reg   <= acc_next;
      phase_reg <= phase_next;
      ce_reg    <= ce_next;
      ph1_reg   <= ph1_next;
      ph2_reg   <= ph2_next;
    end
  end

  assign ce  = ce_reg;
  assign ph1 = ph1_reg;
  assign ph2 = ph2_reg;

endmodule

// File: rtl/cr_ce_gen.sv
// N-channel fractional clock-enable generator with runtime-programmable ratios.
module cr_ce_gen
  import cr_ce_pkg::*;
#(
  parameter int CHANNELS      = 2,
  parameter int INC_W         = 16,
  parameter int DEF_INC       = CE_DEF_INC,
  parameter int DEF_MOD       = CE_DEF_MOD,
  parameter bit DEF_TWO_PHASE = CE_DEF_TWO_PHASE
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic                                              run,
  input  logic                                              sync,
  input  logic                                              cfg_we,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
  input  logic [INC_W-1:0]                                  cfg_inc,
  input  logic [INC_W-1:0]                                  cfg_mod,
  input  logic                                              cfg_two_phase,
  output logic [CHANNELS-1:0]                               ce,
  output logic [CHANNELS-1:0]                               ph1,
  output logic [CHANNELS-1:0]                               ph2
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  ce_cfg_t cfg_bus;

  // Widen the write data into the shared configuration record.
  always_comb begin
    cfg_bus.inc       = CE_CFG_W'(cfg_inc);
    cfg_bus.mod       = CE_CFG_W'(cfg_mod);
    cfg_bus.two_phase = cfg_two_phase;
  end

  // Out-of-range channel numbers match no instance, so such writes fall away.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic chan_we;
    assign chan_we = cfg_we && (cfg_ch == CH_W'(gi));

    cr_ce_chan #(
      .INC_W         (INC_W),
      .DEF_INC       (DEF_INC),
      .DEF_MOD       (DEF_MOD),
      .DEF_TWO_PHASE (DEF_TWO_PHASE)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (run),
      .sync    (sync),
      .cfg_we  (chan_we),
      .cfg     (cfg_bus),
      .ce      (ce[gi]),
      .ph1     (ph1[gi]),
      .ph2     (ph2[gi])
    );
  end

endmodule

// File: tb/tb_cr_ce_gen.sv
// Self-checking bench for cr_ce_gen: vector table, directed corner cases, random run.
module tb_cr_ce_gen;

  localparam int CH = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            run = 1'b0;
  logic            sync = 1'b0;
  logic            cfg_we = 1'b0;
  logic [0:0]      cfg_ch = '0;
  logic [15:0]     cfg_inc = '0;
  logic [15:0]     cfg_mod = '0;
  logic            cfg_two_phase = 1'b0;
  logic [CH-1:0]   ce, ph1, ph2;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles accumulated since the last clear; the tick count is
  // floor(n*einc/mod) and a tick happens when that count increases.
  longint m_n [CH];
  longint m_inc [CH];
  longint m_mod [CH];
  bit     m_tp [CH];
  logic [CH-1:0] exp_ce, exp_ph1, exp_ph2;

  cr_ce_gen #(.CHANNELS(CH), .INC_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .sync(sync), .cfg_we(cfg_we),
    .cfg_ch(cfg_ch), .cfg_inc(cfg_inc), .cfg_mod(cfg_mod),
    .cfg_two_phase(cfg_two_phase), .ce(ce), .ph1(ph1), .ph2(ph2)
  );

  always #5 clk = ~clk;

  task automatic model_edge(bit r_n, bit r, bit s, bit we, int ch, int inc, int md, bit tp);
    longint e, k, kp;
    for (int c = 0; c < CH; c++) begin
      exp_ce[c] = 1'b0; exp_ph1[c] = 1'b0; exp_ph2[c] = 1'b0;
      if (!r_n) begin
        m_inc[c] = 2328; m_mod[c] = 25000; m_tp[c] = 1'b1; m_n[c] = 0;
      end else if ((we && ch == c) || s) begin
        m_n[c] = 0;
        if (we && ch == c) begin
          m_inc[c] = inc; m_mod[c] = md; m_tp[c] = tp;
        end
      end else if (r && m_mod[c] != 0) begin
        e = (m_inc[c] > m_mod[c]) ? m_mod[c] : m_inc[c];
        m_n[c]++;
        k  = (m_n[c] * e) / m_mod[c];
        kp = ((m_n[c] - 1) * e) / m_mod[c];
        if (k > kp) begin
          exp_ce[c]  = 1'b1;
          exp_ph1[c] = m_tp[c] && ((k - 1) % 2 == 0);
          exp_ph2[c] = m_tp[c] && ((k - 1) % 2 == 1);
        end
      end
    end
  endtask

  // One clock: drive inputs, update the model on the edge, compare 1 ns later.
  task automatic step(bit r_n, bit r, bit s, bit we, int ch, int inc, int md, bit tp);
    reset_n = r_n; run = r; sync = s; cfg_we = we;
    cfg_ch = 1'(ch); cfg_inc = 16'(inc); cfg_mod = 16'(md); cfg_two_phase = tp;
    @(posedge clk);
    model_edge(r_n, r, s, we, ch, inc, md, tp);
    #1;
    for (int c = 0; c < CH; c++) begin
      checks++;
      if ({ce[c], ph1[c], ph2[c]} !== {exp_ce[c], exp_ph1[c], exp_ph2[c]}) begin
        errors++;
        if (errors <= 20)
          $display("FAIL model ch%0d t=%0t: got ce/ph1/ph2=%b%b%b want %b%b%b", c, $time,
                   ce[c], ph1[c], ph2[c], exp_ce[c], exp_ph1[c], exp_ph2[c]);
      end
    end
  endtask

  task automatic check(string name, longint got, longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end else begin
      $display("check %s: %0d ok", name, got);
    end
  endtask

  // Run free until channel c ticks; cyc is the 1-based cycle count or -1 on timeout.
  task automatic run_until_tick(int c, int limit, output int cyc, output bit p1);
    cyc = -1; p1 = 1'b0;
    for (int i = 1; i <= limit; i++) begin
      step(1, 1, 0, 0, 0, 0, 0, 0);
      if (ce[c]) begin
        cyc = i; p1 = ph1[c];
        break;
      end
    end
  endtask

  typedef struct {
    bit r, s, we;
    int ch, inc, md;
    bit tp;
    logic [1:0] ce, ph1, ph2;
  } vec_t;

  vec_t vecs [16];

  initial begin
    int cyc, cnt, cnt1;
    bit p1;

    // rows: run sync we ch inc mod tp | ce ph1 ph2 (bit1 = channel 1)
    vecs[0]  = '{1,0,1,0,1,2,1, 2'b00,2'b00,2'b00};
    vecs[1]  = '{1,0,1,1,1,4,0, 2'b00,2'b00,2'b00};
    vecs[2]  = '{1,0,0,0,0,0,0, 2'b01,2'b01,2'b00};
    vecs[3]  = '{1,0,0,0,0,0,0, 2'b00,2'b00,2'b00};
    vecs[4]  = '{1,0,0,0,0,0,0, 2'b01,2'b00,2'b01};
    vecs[5]  = '{1,0,0,0,0,0,0, 2'b10,2'b00,2'b00};
    vecs[6]  = '{1,1,0,0,0,0,0, 2'b00,2'b00,2'b00};
    vecs[7]  = '{1,0,0,0,0,0,0, 2'b00,2'b00,2'b00};
    vecs[8]  = '{1,0,0,0,0,0,0, 2'b01,2'b01,2'b00};
    vecs[9]  = '{0,0,0,0,0,0,0, 2'b00,2'b00,2'b00};
    vecs[10] = '{1,0,0,0,0,0,0, 2'b00,2'b00,2'b00};
    vecs[11] = '{1,0,0,0,0,0,0, 2'b11,2'b00,2'b01};
    vecs[12] = '{1,0,1,0,5,3,0, 2'b00,2'b00,2'b00};
    vecs[13] = '{1,0,0,0,0,0,0, 2'b01,2'b00,2'b00};
    vecs[14] = '{1,0,0,0,0,0,0, 2'b01,2'b00,2'b00};
    vecs[15] = '{1,0,0,0,0,0,0, 2'b11,2'b00,2'b00};

    // Reset state
    step(0, 1, 1, 1, 0, 9, 9, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    check("reset_outputs", longint'({ce, ph1, ph2}), 0);

    // Vector table
    foreach (vecs[i]) begin
      step(1, vecs[i].r, vecs[i].s, vecs[i].we, vecs[i].ch, vecs[i].inc, vecs[i].md, vecs[i].tp);
      checks++;
      if ({ce, ph1, ph2} !== {vecs[i].ce, vecs[i].ph1, vecs[i].ph2}) begin
        errors++;
        $display("FAIL vec%0d: got ce=%b ph1=%b ph2=%b want ce=%b ph1=%b ph2=%b", i,
                 ce, ph1, ph2, vecs[i].ce, vecs[i].ph1, vecs[i].ph2);
      end else begin
        $display("vec%0d: ce=%b ph1=%b ph2=%b ok", i, ce, ph1, ph2);
      end
    end

    // Default ratio: first tick at cycle 11 edge (visible in cycle 12), ph1 then ph2
    step(0, 0, 0, 0, 0, 0, 0, 0);
    run_until_tick(0, 50, cyc, p1);
    check("default_first_tick", cyc, 11);
    check("default_first_ph1", p1, 1);
    run_until_tick(0, 50, cyc, p1);
    check("default_second_is_ph2", longint'(ph2[0]), 1);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 25000; i++) begin
      step(1, 1, 0, 0, 0, 0, 0, 0);
      if (ce[0]) cnt++;
    end
    check("default_25000_cycles", cnt, 2328);

    // Disable: inc=0 on channel 1, mod=0 on channel 0
    step(1, 1, 0, 1, 1, 0, 7, 1);
    step(1, 1, 0, 1, 0, 3, 0, 1);
    cnt = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1, 1, 0, 0, 0, 0, 0, 0);
      cnt += int'(ce[0]) + int'(ce[1]);
    end
    check("disabled_no_ticks", cnt, 0);

    // Sync mid-operation with a simultaneous write to channel 1
    step(1, 1, 0, 1, 0, 3, 10, 1);
    step(1, 1, 0, 1, 1, 7, 20, 1);
    for (int i = 0; i < 37; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 1, 1, 5, 1);
    cnt = -1; cnt1 = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1, 1, 0, 0, 0, 0, 0, 0);
      if (ce[0] && cnt < 0) begin cnt = i; check("sync_ch0_ph1", ph1[0], 1); end
      if (ce[1] && cnt1 < 0) begin cnt1 = i; check("sync_ch1_ph1", ph1[1], 1); end
    end
    check("sync_ch0_first", cnt, 4);
    check("sync_ch1_first_new_cfg", cnt1, 5);

    // Freeze: 100 cycles with run low, then the model checks the continuation
    for (int i = 0; i < 13; i++) step(1, 1, 0, 0, 0, 0, 0, 0);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      step(1, 0, 0, 0, 0, 0, 0, 0);
      cnt += int'(ce[0]) + int'(ce[1]);
    end
    check("freeze_no_ticks", cnt, 0);
    for (int i = 0; i < 30; i++) step(1, 1, 0, 0, 0, 0, 0, 0);

    // Randomised traffic against the model
    for (int i = 0; i < 4000; i++) begin
      bit r_n, r, s, we, big;
      int md, inc;
      r_n = ($urandom_range(0, 499) != 0);
      r   = ($urandom_range(0, 9) != 0);
      s   = ($urandom_range(0, 99) == 0);
      we  = ($urandom_range(0, 49) == 0);
      big = ($urandom_range(0, 3) == 0);
      md  = big ? int'($urandom_range(1, 65535)) : int'($urandom_range(0, 40));
      inc = big ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 50));
      step(r_n, r, s, we, int'($urandom_range(0, 1)), inc, md, 1'($urandom_range(0, 1)));
    end
    $display("random phase done at %0d checks", checks);

    // Reset mid-operation after reprogramming both channels
    step(1, 1, 0, 1, 0, 1, 1, 1);
    step(1, 1, 0, 1, 1, 1, 1, 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0, 0);
    check("midreset_outputs", longint'({ce, ph1, ph2}), 0);
    run_until_tick(1, 50, cyc, p1);
    check("midreset_default_first_tick", cyc, 11);
    check("midreset_first_ph1", p1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
